// File: rtl/cpu_sequencer.sv
// Program buffer and sequencer that replaces manual load/start keys for the cpu block.
// Words are appended in IDLE, then each one is loaded, started and waited on until w cycles low->high.
//
// state    | meaning
// IDLE     | accepting buffer writes, waiting for run
// LOAD     | cpu_load pulse, cpu_in takes entry[pc] on exit
// START    | cpu_s pulse, timer cleared
// WAIT_LO  | waiting for cpu_w to drop
// WAIT_HI  | waiting for cpu_w to rise again
// NEXT     | advance pc or finish
// PAUSE    | single-step hold, run resumes
// DONE     | buffer executed, run repeats, clr empties
// ERR      | wait timed out, only clr leaves
module cpu_sequencer #(
    parameter int DEPTH   = 8,
    parameter int AW      = 3,
    parameter int TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr_en,
    input  logic [15:0]   wr_data,
    input  logic          run,
    input  logic          step,
    input  logic          clr,
    input  logic          cpu_w,
    output logic [15:0]   cpu_in,
    output logic          cpu_load,
    output logic          cpu_s,
    output logic [AW-1:0] pc,
    output logic [AW:0]   count,
    output logic          busy,
    output logic          done,
    output logic          err
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);
    localparam logic [AW:0]   FULL   = (AW + 1)'(DEPTH);

    typedef enum logic [3:0] {
        S_IDLE, S_LOAD, S_START, S_WAIT_LO, S_WAIT_HI, S_NEXT, S_PAUSE, S_DONE, S_ERR
    } state_t;

    state_t        state;
    logic [TW-1:0] timer;
    logic [TW-1:0] timer_inc;
    logic [15:0]   mem [DEPTH];
    logic          wr_ok;
    logic          last;

    assign wr_ok     = (state == S_IDLE) && wr_en && (count < FULL);
    assign last      = ({1'b0, pc} == (count - (AW + 1)'(1)));
    // Saturate so a stuck timer can never wrap back below the terminal count.
    assign timer_inc = (timer == '1) ? timer : timer + TW'(1);

    function automatic logic [2:0] status(input state_t s);
        case (s)
            S_LOAD, S_START, S_WAIT_LO, S_WAIT_HI, S_NEXT, S_PAUSE: status = 3'b100;
            S_DONE:  status = 3'b010;
            S_ERR:   status = 3'b001;
            default: status = 3'b000;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (wr_ok) mem[count[AW-1:0]] <= wr_data;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            cpu_in   <= '0;
            cpu_load <= 1'b0;
            cpu_s    <= 1'b0;
            pc       <= '0;
            count    <= '0;
            timer    <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            cpu_load <= 1'b0;
            cpu_s    <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (wr_ok) begin
                        count <= count + (AW + 1)'(1);
                    end else if (run && count != '0) begin
                        pc                 <= '0;
                        cpu_load           <= 1'b1;
                        state              <= S_LOAD;
                        {busy, done, err}  <= status(S_LOAD);
                    end
                end
                S_LOAD: begin
                    cpu_in            <= mem[pc];
                    cpu_s             <= 1'b1;
                    state             <= S_START;
                    {busy, done, err} <= status(S_START);
                end
                S_START: begin
                    timer             <= '0;
                    state             <= S_WAIT_LO;
                    {busy, done, err} <= status(S_WAIT_LO);
                end
                S_WAIT_LO: begin
                    if (!cpu_w) begin
                        timer             <= '0;
                        state             <= S_WAIT_HI;
                        {busy, done, err} <= status(S_WAIT_HI);
                    end else if (timer == T_LAST) begin
                        state             <= S_ERR;
                        {busy, done, err} <= status(S_ERR);
                    end else begin
                        timer <= timer_inc;
                    end
                end
                S_WAIT_HI: begin
                    if (cpu_w) begin
                        state             <= S_NEXT;
                        {busy, done, err} <= status(S_NEXT);
                    end else if (timer == T_LAST) begin
                        state             <= S_ERR;
                        {busy, done, err} <= status(S_ERR);
                    end else begin
                        timer <= timer_inc;
                    end
                end
                S_NEXT: begin
                    if (last) begin
                        state             <= S_DONE;
                        {busy, done, err} <= status(S_DONE);
                    end else begin
                        pc <= pc + AW'(1);
                        if (step) begin
                            state             <= S_PAUSE;
                            {busy, done, err} <= status(S_PAUSE);
                        end else begin
                            cpu_load          <= 1'b1;
                            state             <= S_LOAD;
                            {busy, done, err} <= status(S_LOAD);
                        end
                    end
                end
                S_PAUSE: begin
                    if (run) begin
                        cpu_load          <= 1'b1;
                        state             <= S_LOAD;
                        {busy, done, err} <= status(S_LOAD);
                    end
                end
                S_DONE: begin
                    if (clr) begin
                        count             <= '0;
                        pc                <= '0;
                        state             <= S_IDLE;
                        {busy, done, err} <= status(S_IDLE);
                    end else if (run) begin
                        pc                <= '0;
                        cpu_load          <= 1'b1;
                        state             <= S_LOAD;
                        {busy, done, err} <= status(S_LOAD);
                    end
                end
                S_ERR: begin
                    if (clr) begin
                        count             <= '0;
                        pc                <= '0;
                        state             <= S_IDLE;
                        {busy, done, err} <= status(S_IDLE);
                    end
                end
                default: begin
                    state             <= S_IDLE;
                    {busy, done, err} <= status(S_IDLE);
                end
            endcase
        end
    end

endmodule
